modulus_lut_bank: RTL



---
 rtl/modulus_lut_pkg.sv | 33 +++
 rtl/modulus_lut_table.sv | 50 +++++
 rtl/modulus_lut_bank.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/modulus_lut_pkg.sv
// Shared types and elaboration-time helpers for the modulus reduction lookup bank.
package modulus_lut_pkg;

  // Load/readback FSM states.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    VALID = 2'd2
  } lut_state_e;

  // Index width for a counter over n positions; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  // Number of output terms (one table per segment of every chunk).
  function automatic int terms_of(input int num_chunks, input int segs_per_chunk);
    return num_chunks * segs_per_chunk;
  endfunction

  // Number of words streamed in for one complete set of tables.
  function automatic int load_words_of(input int num_terms, input int seg_bits,
                                       input int num_out_words);
    return num_terms * (32'sd1 << seg_bits) * num_out_words;
  endfunction

  // Phase group of a chunk; chunks are split into contiguous groups.
  function automatic int phase_of(input int chunk, input int num_chunks,
                                  input int num_phases);
    return (chunk * num_phases) / num_chunks;
  endfunction

endpackage

// File: rtl/modulus_lut_table.sv
// One lookup table: 2^SEG_BITS entries of NUM_OUT_WORDS words each.
// Written one word at a time; read through a register that can be cleared,
// held (rd_en low) or loaded with zero (rd_zero) instead of the table entry.
module modulus_lut_table
  import modulus_lut_pkg::*;
#(
  parameter int WORD_LEN      = 50,
  parameter int NUM_OUT_WORDS = 21,
  parameter int SEG_BITS      = 6,
  localparam int WORD_IDX_W   = idx_width(NUM_OUT_WORDS),
  localparam int ENTRIES      = 32'sd1 << SEG_BITS
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    wr_en,
  input  logic [SEG_BITS-1:0]                     wr_entry,
  input  logic [WORD_IDX_W-1:0]                   wr_word,
  input  logic [WORD_LEN-1:0]                     wr_data,
  input  logic                                    rd_en,
  input  logic                                    rd_clr,
  input  logic                                    rd_zero,
  input  logic [SEG_BITS-1:0]                     rd_addr,
  output logic [NUM_OUT_WORDS-1:0][WORD_LEN-1:0]  rd_data
);

  logic [WORD_LEN-1:0] mem_r [ENTRIES][NUM_OUT_WORDS];

  // Word-granular write port; storage has no reset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_entry][wr_word] <= wr_data;
    end
  end

  // Registered read: clear has priority, then enabled update, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int w = 0; w < NUM_OUT_WORDS; w++) begin
        rd_data[w] <= rd_zero ? {WORD_LEN{1'b0}} : mem_r[rd_addr][w];
      end
    end else begin
      rd_data <= rd_data;
    end
  end

endmodule

// File: rtl/modulus_lut_bank.sv
// Runtime-loadable reduction lookup bank. Tables are streamed in through a
// valid/ready port in word, entry, segment, chunk order (word innermost);
// once every table is loaded, each chunk's segments look up their tables on
// that chunk's phase strobe and drive the selected multiples as output terms.
module modulus_lut_bank
  import modulus_lut_pkg::*;
#(
  parameter int WORD_LEN       = 50,
  parameter int NUM_OUT_WORDS  = 21,
  parameter int NUM_CHUNKS     = 22,
  parameter int SEGS_PER_CHUNK = 8,
  parameter int SEG_BITS       = 6,
  parameter int NUM_PHASES     = 3,
  localparam int NUM_TERMS     = terms_of(NUM_CHUNKS, SEGS_PER_CHUNK),
  localparam int LOAD_WORDS    = load_words_of(NUM_TERMS, SEG_BITS, NUM_OUT_WORDS)
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic [NUM_PHASES-1:0]                                  clk_phase,
  input  logic                                                   ce,
  input  logic [NUM_CHUNKS-1:0]                                  bypass,
  input  logic [NUM_CHUNKS-1:0][SEGS_PER_CHUNK*SEG_BITS-1:0]     lut_addrs,
  output logic [NUM_OUT_WORDS-1:0][NUM_TERMS-1:0][WORD_LEN-1:0]  lut_datas,
  input  logic                                                   ld_start,
  input  logic                                                   ld_valid,
  input  logic [WORD_LEN-1:0]                                    ld_data,
  output logic                                                   ld_ready,
  output logic                                                   ld_done,
  output logic                                                   tables_valid
);

  localparam int WORD_IDX_W  = idx_width(NUM_OUT_WORDS);
  localparam int SEG_IDX_W   = idx_width(SEGS_PER_CHUNK);
  localparam int CHUNK_IDX_W = idx_width(NUM_CHUNKS);

  lut_state_e               state_r;
  lut_state_e               state_s;
  logic [WORD_IDX_W-1:0]    word_cnt_r;
  logic [SEG_BITS-1:0]      entry_cnt_r;
  logic [SEG_IDX_W-1:0]     seg_cnt_r;
  logic [CHUNK_IDX_W-1:0]   chunk_cnt_r;
  logic                     ld_done_r;
  logic                     accept_s;
  logic                     word_last_s;
  logic                     entry_last_s;
  logic                     seg_last_s;
  logic                     chunk_last_s;
  logic                     last_accept_s;
  logic                     rd_clr_s;
  logic [NUM_OUT_WORDS-1:0][WORD_LEN-1:0] term_data_s [NUM_TERMS];

  // ld_start always wins over a coincident word, so ready drops with it.
  assign ld_ready      = (state_r == LOAD) && !ld_start;
  assign accept_s      = ld_ready && ld_valid;
  assign word_last_s   = (word_cnt_r  == WORD_IDX_W'(NUM_OUT_WORDS - 1));
  assign entry_last_s  = (entry_cnt_r == {SEG_BITS{1'b1}});
  assign seg_last_s    = (seg_cnt_r   == SEG_IDX_W'(SEGS_PER_CHUNK - 1));
  assign chunk_last_s  = (chunk_cnt_r == CHUNK_IDX_W'(NUM_CHUNKS - 1));
  assign last_accept_s = accept_s && word_last_s && entry_last_s && seg_last_s && chunk_last_s;
  assign rd_clr_s      = (state_r != VALID);
  assign tables_valid  = (state_r == VALID);
  assign ld_done       = ld_done_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state: any ld_start (re)enters LOAD; the final word enters VALID.
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: begin
        if (ld_start) state_s = LOAD;
        else          state_s = EMPTY;
      end
      LOAD: begin
        if (ld_start)           state_s = LOAD;
        else if (last_accept_s) state_s = VALID;
        else                    state_s = LOAD;
      end
      VALID: begin
        if (ld_start) state_s = LOAD;
        else          state_s = VALID;
      end
      default: state_s = EMPTY;
    endcase
  end

  // Load position counters, word innermost, cleared by ld_start.
  always_ff @(posedge clk) begin
    if (!rst_n || ld_start) begin
      word_cnt_r  <= '0;
      entry_cnt_r <= '0;
      seg_cnt_r   <= '0;
      chunk_cnt_r <= '0;
    end else if (accept_s) begin
      if (!word_last_s) begin
        word_cnt_r <= word_cnt_r + WORD_IDX_W'(1'b1);
      end else begin
        word_cnt_r <= '0;
        if (!entry_last_s) begin
          entry_cnt_r <= entry_cnt_r + SEG_BITS'(1'b1);
        end else begin
          entry_cnt_r <= '0;
          if (!seg_last_s) begin
            seg_cnt_r <= seg_cnt_r + SEG_IDX_W'(1'b1);
          end else begin
            seg_cnt_r   <= '0;
            chunk_cnt_r <= chunk_last_s ? '0 : chunk_cnt_r + CHUNK_IDX_W'(1'b1);
          end
        end
      end
    end
  end

  // One-cycle completion pulse, aligned with tables_valid rising.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_done_r <= 1'b0;
    end else begin
      ld_done_r <= last_accept_s;
    end
  end

  for (genvar c = 0; c < NUM_CHUNKS; c++) begin : g_chunk
    localparam int PHASE = phase_of(c, NUM_CHUNKS, NUM_PHASES);
    for (genvar s = 0; s < SEGS_PER_CHUNK; s++) begin : g_seg
      localparam int TERM = c * SEGS_PER_CHUNK + s;
      logic we_s;

      assign we_s = accept_s && (chunk_cnt_r == CHUNK_IDX_W'(c)) &&
                    (seg_cnt_r == SEG_IDX_W'(s));

      modulus_lut_table #(
        .WORD_LEN      (WORD_LEN),
        .NUM_OUT_WORDS (NUM_OUT_WORDS),
        .SEG_BITS      (SEG_BITS)
      ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (we_s),
        .wr_entry (entry_cnt_r),
        .wr_word  (word_cnt_r),
        .wr_data  (ld_data),
        .rd_en    (ce && clk_phase[PHASE]),
        .rd_clr   (rd_clr_s),
        .rd_zero  (bypass[c]),
        .rd_addr  (lut_addrs[c][s*SEG_BITS +: SEG_BITS]),
        .rd_data  (term_data_s[TERM])
      );

      for (genvar w = 0; w < NUM_OUT_WORDS; w++) begin : g_word
        assign lut_datas[w][TERM] = term_data_s[TERM][w];
      end
    end
  end

endmodule
